// File: rtl/irq_arbiter.sv
// irq_arbiter: merges the keyboard and Ethernet interrupt sources into one
// interrupt request for the pipelined core. Each source has a small FIFO
// for its payload words. Only one interrupt is in service at a time.
//
// Build option: define IRQ_ARB_RR_EN to get round-robin arbitration between
// the two sources. Without it, Ethernet always wins over keyboard.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | nothing in service; issue when a FIFO has data and core is idle
// ST_ISSUE   | one-cycle irq pulse, payload and source latched on the outputs
// ST_SERVICE | handler running in the core; wait for the RTI/RSI pulse
module irq_arbiter #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_req,
   input  logic [DATA_W-1:0] key_data,
   input  logic              eth_req,
   input  logic [DATA_W-1:0] eth_data,
   input  logic              cpu_busy,
   input  logic              irq_done,
   output logic              irq,
   output logic [DATA_W-1:0] irq_data,
   output logic              irq_src,
   output logic              in_service,
   output logic [1:0]        pending,
   output logic [1:0]        overflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Index 0 is the keyboard source and index 1 is the Ethernet source.
   // This matches irq_src and the bit order of pending/overflow.
   logic [1:0]        req_in;
   logic [1:0]        req_q;
   logic [DATA_W-1:0] data_in  [2];
   logic [DATA_W-1:0] mem_q    [2][DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q [2];
   logic [PTR_W-1:0]  wr_ptr_d [2];
   logic [PTR_W-1:0]  rd_ptr_q [2];
   logic [PTR_W-1:0]  rd_ptr_d [2];
   logic [CNT_W-1:0]  cnt_q    [2];
   logic [CNT_W-1:0]  cnt_d    [2];

   logic [1:0] evt;
   logic [1:0] pend;
   logic [1:0] full;
   logic [1:0] push;
   logic [1:0] pop;
   logic [1:0] ovf_q, ovf_d;
   logic       win;
   logic       issue;

   logic              irq_q, irq_d;
   logic              in_service_q, in_service_d;
   logic              irq_src_q, irq_src_d;
   logic [DATA_W-1:0] irq_data_q, irq_data_d;

`ifdef IRQ_ARB_RR_EN
   logic last_grant_q, last_grant_d;
`endif

   assign req_in     = {eth_req, key_req};
   assign data_in[0] = key_data;
   assign data_in[1] = eth_data;

   // Per-source status: rising-edge event, FIFO non-empty and FIFO full
   always_comb begin
      evt  = '0;
      pend = '0;
      full = '0;
      for (int s = 0; s < 2; s++) begin
         evt[s]  = req_in[s] & ~req_q[s];
         pend[s] = (cnt_q[s] != '0);
         full[s] = (cnt_q[s] == CNT_W'(DEPTH));
      end
   end

   // Winner selection and the issue decision (only from idle with the core quiet)
   always_comb begin
      win = pend[1];
`ifdef IRQ_ARB_RR_EN
      if (pend == 2'b11) begin
         win = ~last_grant_q;
      end
`endif
      issue = (state_q == ST_IDLE) && (pend != 2'b00) && !cpu_busy;
      pop   = {issue & win, issue & ~win};
   end

   // FIFO bookkeeping: a pop in the same edge frees the slot a full push needs
   always_comb begin
      push     = '0;
      ovf_d    = ovf_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      for (int s = 0; s < 2; s++) begin
         push[s]  = evt[s] & (~full[s] | pop[s]);
         ovf_d[s] = ovf_q[s] | (evt[s] & full[s] & ~pop[s]);
         if (push[s]) begin
            wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(1);
         end
         if (pop[s]) begin
            rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
         end
         case ({push[s], pop[s]})
            2'b10:   cnt_d[s] = cnt_q[s] + CNT_W'(1);
            2'b01:   cnt_d[s] = cnt_q[s] - CNT_W'(1);
            default: cnt_d[s] = cnt_q[s];
         endcase
      end
   end

   // Next state, latched payload/source, and registered irq/in_service
   always_comb begin
      state_d    = state_q;
      irq_data_d = irq_data_q;
      irq_src_d  = irq_src_q;
`ifdef IRQ_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (issue) begin
               state_d    = ST_ISSUE;
               irq_data_d = mem_q[win][rd_ptr_q[win]];
               irq_src_d  = win;
`ifdef IRQ_ARB_RR_EN
               last_grant_d = win;
`endif
            end
         end
         ST_ISSUE:   state_d = ST_SERVICE;
         ST_SERVICE: begin
            if (irq_done) begin
               state_d = ST_IDLE;
            end
         end
         default:    state_d = ST_IDLE;
      endcase
      irq_d        = (state_d == ST_ISSUE);
      in_service_d = (state_d != ST_IDLE);
   end

   // Payload storage; a write to the head slot in the same edge as its pop is safe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < 2; s++) begin
            for (int d = 0; d < DEPTH; d++) begin
               mem_q[s][d] <= '0;
            end
         end
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
               mem_q[s][wr_ptr_q[s]] <= data_in[s];
            end
         end
      end
   end

   // State, pointers, counts, edge detect and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         req_q        <= '0;
         ovf_q        <= '0;
         irq_q        <= 1'b0;
         in_service_q <= 1'b0;
         irq_src_q    <= 1'b0;
         irq_data_q   <= '0;
         for (int s = 0; s < 2; s++) begin
            wr_ptr_q[s] <= '0;
            rd_ptr_q[s] <= '0;
            cnt_q[s]    <= '0;
         end
      end else begin
         state_q      <= state_d;
         req_q        <= req_in;
         ovf_q        <= ovf_d;
         irq_q        <= irq_d;
         in_service_q <= in_service_d;
         irq_src_q    <= irq_src_d;
         irq_data_q   <= irq_data_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
      end
   end

`ifdef IRQ_ARB_RR_EN
   // Remembers which source was granted last so the other one wins a tie next time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   assign irq        = irq_q;
   assign irq_data   = irq_data_q;
   assign irq_src    = irq_src_q;
   assign in_service = in_service_q;
   assign pending    = pend;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Testbench for irq_arbiter. It checks the design against a queue-based
// reference model after every clock edge.
module tb_irq_arbiter;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              key_req = 1'b0;
   logic [DATA_W-1:0] key_data = '0;
   logic              eth_req = 1'b0;
   logic [DATA_W-1:0] eth_data = '0;
   logic              cpu_busy = 1'b0;
   logic              irq_done = 1'b0;
   logic              irq;
   logic [DATA_W-1:0] irq_data;
   logic              irq_src;
   logic              in_service;
   logic [1:0]        pending;
   logic [1:0]        overflow;

   always #5 clk = ~clk;

   irq_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_req    (key_req),
      .key_data   (key_data),
      .eth_req    (eth_req),
      .eth_data   (eth_data),
      .cpu_busy   (cpu_busy),
      .irq_done   (irq_done),
      .irq        (irq),
      .irq_data   (irq_data),
      .irq_src    (irq_src),
      .in_service (in_service),
      .pending    (pending),
      .overflow   (overflow)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: one queue per source plus the in-service bookkeeping
   logic [DATA_W-1:0] kq[$];
   logic [DATA_W-1:0] eq[$];
   logic              m_irq, m_srv, m_src, m_last;
   logic [DATA_W-1:0] m_data;
   logic [1:0]        m_ovf;
   logic              prev_k, prev_e;

   task automatic model_reset();
      kq.delete();
      eq.delete();
      m_irq = 0; m_srv = 0; m_src = 0; m_last = 0;
      m_data = '0; m_ovf = '0; prev_k = 0; prev_e = 0;
   endtask

   task automatic model_step();
      logic ek, ee, was_issue, idle, w;
      ek = key_req && !prev_k;
      ee = eth_req && !prev_e;
      was_issue = m_irq;
      idle = !m_srv;
      m_irq = 0;
      if (m_srv && !was_issue && irq_done) m_srv = 0;
      if (idle && !cpu_busy && (kq.size() != 0 || eq.size() != 0)) begin
         if (kq.size() != 0 && eq.size() != 0) begin
`ifdef IRQ_ARB_RR_EN
            w = !m_last;
`else
            w = 1'b1;
`endif
         end else begin
            w = (eq.size() != 0);
         end
         if (w) m_data = eq.pop_front();
         else   m_data = kq.pop_front();
         m_src = w; m_last = w; m_irq = 1; m_srv = 1;
      end
      if (ek) begin
         if (kq.size() < DEPTH) kq.push_back(key_data);
         else m_ovf[0] = 1'b1;
      end
      if (ee) begin
         if (eq.size() < DEPTH) eq.push_back(eth_data);
         else m_ovf[1] = 1'b1;
      end
      prev_k = key_req;
      prev_e = eth_req;
   endtask

   task automatic compare_all();
      check_eq("irq",        irq,        m_irq);
      check_eq("irq_data",   irq_data,   m_data);
      check_eq("irq_src",    irq_src,    m_src);
      check_eq("in_service", in_service, m_srv);
      check_eq("pending",    pending,    {eq.size() != 0, kq.size() != 0});
      check_eq("overflow",   overflow,   m_ovf);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         if (rst_n) model_step();
         else model_reset();
         #1;
         compare_all();
      end
   endtask

   task automatic pulse_done();
      irq_done = 1'b1;
      tick(1);
      irq_done = 1'b0;
   endtask

   initial begin
      model_reset();
      #12;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);

      // single keyboard event
      key_data = 32'hA5; key_req = 1'b1; tick(1);
      key_req = 1'b0; tick(3);
      pulse_done(); tick(2);

      // simultaneous events, done twice so round-robin state is exercised
      repeat (2) begin
         key_data = 32'd1; eth_data = 32'd2;
         key_req = 1'b1; eth_req = 1'b1; tick(1);
         key_req = 1'b0; eth_req = 1'b0; tick(3);
         pulse_done(); tick(3);
         pulse_done(); tick(2);
      end

      // event held off by a busy core
      cpu_busy = 1'b1; key_data = 32'h77; key_req = 1'b1; tick(1);
      key_req = 1'b0; tick(4);
      cpu_busy = 1'b0; tick(3);
      pulse_done(); tick(2);

      // overflow: three keyboard events while Ethernet is in service
      eth_data = 32'hE0; eth_req = 1'b1; tick(1);
      eth_req = 1'b0; tick(3);
      for (int v = 1; v <= 3; v++) begin
         key_data = DATA_W'(v); key_req = 1'b1; tick(1);
         key_req = 1'b0; tick(1);
      end
      pulse_done(); tick(3);
      pulse_done(); tick(3);
      pulse_done(); tick(2);

      // held level is a single event; irq_done in idle is ignored
      key_data = 32'h10; key_req = 1'b1; tick(10);
      pulse_done(); key_req = 1'b0; tick(2);
      pulse_done(); tick(3);

      // reset in the middle of service with both FIFOs holding data
      eth_data = 32'hE1; eth_req = 1'b1; tick(1);
      eth_req = 1'b0; tick(2);
      key_data = 32'h21; eth_data = 32'hE2;
      key_req = 1'b1; eth_req = 1'b1; tick(1);
      key_req = 1'b0; eth_req = 1'b0; tick(1);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      tick(2);
      @(negedge clk);
      rst_n = 1'b1;
      tick(5);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) key_req = ~key_req;
         if ($urandom_range(0, 3) == 0) eth_req = ~eth_req;
         key_data = $urandom;
         eth_data = $urandom;
         cpu_busy = ($urandom_range(0, 3) == 0);
         irq_done = ($urandom_range(0, 4) == 0);
         tick(1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
